// File: rtl/mem_disp_pkg.sv
// Shared glyph codes, FSM state type and nibble helper for the memory status display.
package mem_disp_pkg;

  localparam logic [4:0] GLYPH_R     = 5'd16;
  localparam logic [4:0] GLYPH_D     = 5'd17;
  localparam logic [4:0] GLYPH_T     = 5'd18;
  localparam logic [4:0] GLYPH_US    = 5'd19;
  localparam logic [4:0] GLYPH_DASH  = 5'd20;
  localparam logic [4:0] GLYPH_N     = 5'd21;
  localparam logic [4:0] GLYPH_BLANK = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_SHOW    = 2'd2
  } state_e;

  function automatic logic [4:0] nib_glyph(input logic [3:0] nib);
    return {1'b0, nib};
  endfunction

endpackage

// File: rtl/mem_disp_ctrl.sv
// Snoops memory transactions and holds a six-digit glyph-code status view;
// times out unanswered reads and keeps a saturating timeout count.
module mem_disp_ctrl
  import mem_disp_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned HOLD_CYC    = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic       req_write,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       req_ready,
  input  logic       rsp_valid,
  input  logic [7:0] rsp_rdata,
  output logic [4:0] hex5_code,
  output logic [4:0] hex4_code,
  output logic [4:0] hex3_code,
  output logic [4:0] hex2_code,
  output logic [4:0] hex1_code,
  output logic [4:0] hex0_code,
  output logic [7:0] timeout_cnt
);

  localparam int WAIT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);

  state_e            state_q, state_d;
  logic [5:0][4:0]   disp_q, disp_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [7:0]        to_q, to_d;
  logic              accept;

  assign req_ready = (state_q != ST_RD_WAIT);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d = state_q;
    disp_d  = disp_q;
    wait_d  = wait_q;
    hold_d  = hold_q;
    to_d    = to_q;

    if (accept) begin
      // A new request preempts whatever IDLE or SHOW was doing.
      disp_d[3] = nib_glyph(req_addr[7:4]);
      disp_d[2] = nib_glyph(req_addr[3:0]);
      if (req_write) begin
        disp_d[5] = GLYPH_T;
        disp_d[4] = GLYPH_BLANK;
        disp_d[1] = nib_glyph(req_wdata[7:4]);
        disp_d[0] = nib_glyph(req_wdata[3:0]);
        state_d   = ST_SHOW;
        hold_d    = '0;
      end else begin
        disp_d[5] = GLYPH_R;
        disp_d[4] = GLYPH_D;
        disp_d[1] = GLYPH_US;
        disp_d[0] = GLYPH_US;
        state_d   = ST_RD_WAIT;
        wait_d    = '0;
      end
    end else begin
      case (state_q)
        ST_RD_WAIT: begin
          // Response wins over a timeout landing on the same edge.
          if (rsp_valid) begin
            disp_d[1] = nib_glyph(rsp_rdata[7:4]);
            disp_d[0] = nib_glyph(rsp_rdata[3:0]);
            state_d   = ST_SHOW;
            hold_d    = '0;
          end else if (wait_q == WAIT_LAST) begin
            disp_d[1] = GLYPH_N;
            disp_d[0] = GLYPH_N;
            if (to_q != 8'hFF) to_d = to_q + 8'd1;
            state_d   = ST_SHOW;
            hold_d    = '0;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
        ST_SHOW: begin
          if (hold_q == HOLD_LAST) begin
            disp_d  = {6{GLYPH_DASH}};
            state_d = ST_IDLE;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      disp_q  <= {6{GLYPH_DASH}};
      wait_q  <= '0;
      hold_q  <= '0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      disp_q  <= disp_d;
      wait_q  <= wait_d;
      hold_q  <= hold_d;
      to_q    <= to_d;
    end
  end

  assign hex5_code   = disp_q[5];
  assign hex4_code   = disp_q[4];
  assign hex3_code   = disp_q[3];
  assign hex2_code   = disp_q[2];
  assign hex1_code   = disp_q[1];
  assign hex0_code   = disp_q[0];
  assign timeout_cnt = to_q;

endmodule

// File: tb/tb_mem_disp_ctrl.sv
// Directed bench for mem_disp_ctrl: deadline-based reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_mem_disp_ctrl;

  localparam int TO   = 4;
  localparam int HOLD = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_write = 1'b0;
  logic [7:0] req_addr = 8'h00;
  logic [7:0] req_wdata = 8'h00;
  logic       req_ready;
  logic       rsp_valid = 1'b0;
  logic [7:0] rsp_rdata = 8'h00;
  logic [4:0] hex5_code, hex4_code, hex3_code, hex2_code, hex1_code, hex0_code;
  logic [7:0] timeout_cnt;

  int checks = 0;
  int errors = 0;

  mem_disp_ctrl #(.TIMEOUT_CYC(TO), .HOLD_CYC(HOLD)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .hex5_code(hex5_code), .hex4_code(hex4_code), .hex3_code(hex3_code),
    .hex2_code(hex2_code), .hex1_code(hex1_code), .hex0_code(hex0_code),
    .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dut_hex(input int i);
    case (i)
      5: return int'(hex5_code);
      4: return int'(hex4_code);
      3: return int'(hex3_code);
      2: return int'(hex2_code);
      1: return int'(hex1_code);
      default: return int'(hex0_code);
    endcase
  endfunction

  task automatic check_disp(input string tag, input int e5, input int e4, input int e3,
                            input int e2, input int e1, input int e0);
    int e[6];
    e[5] = e5; e[4] = e4; e[3] = e3; e[2] = e2; e[1] = e1; e[0] = e0;
    for (int i = 5; i >= 0; i--) check($sformatf("%s_hex%0d", tag, i), dut_hex(i), e[i]);
  endtask

  // Reference model: modes and absolute-cycle deadlines instead of counters.
  int m_mode = 0;            // 0 idle, 1 waiting for read data, 2 showing
  int m_deadline = 0;
  int m_hex[6];
  int m_to = 0;
  int m_cyc = 0;

  task automatic model_reset();
    m_mode = 0;
    m_to = 0;
    for (int i = 0; i < 6; i++) m_hex[i] = 20;
  endtask

  initial begin
    bit r, v, w, rv;
    int a, d, rd;
    model_reset();
    forever begin
      @(posedge clk);
      r = rst_n; v = req_valid; w = req_write; a = req_addr; d = req_wdata;
      rv = rsp_valid; rd = rsp_rdata;
      m_cyc++;
      if (!r) begin
        model_reset();
      end else if (v && m_mode != 1) begin
        m_hex[3] = a / 16;
        m_hex[2] = a % 16;
        if (w) begin
          m_hex[5] = 18; m_hex[4] = 31; m_hex[1] = d / 16; m_hex[0] = d % 16;
          m_mode = 2; m_deadline = m_cyc + HOLD;
        end else begin
          m_hex[5] = 16; m_hex[4] = 17; m_hex[1] = 19; m_hex[0] = 19;
          m_mode = 1; m_deadline = m_cyc + TO;
        end
      end else if (m_mode == 1) begin
        if (rv) begin
          m_hex[1] = rd / 16; m_hex[0] = rd % 16;
          m_mode = 2; m_deadline = m_cyc + HOLD;
        end else if (m_cyc == m_deadline) begin
          m_hex[1] = 21; m_hex[0] = 21;
          if (m_to < 255) m_to++;
          m_mode = 2; m_deadline = m_cyc + HOLD;
        end
      end else if (m_mode == 2 && m_cyc == m_deadline) begin
        m_mode = 0;
        for (int i = 0; i < 6; i++) m_hex[i] = 20;
      end
      #1;
      if (rst_n) begin
        for (int i = 5; i >= 0; i--) check($sformatf("model_hex%0d", i), dut_hex(i), m_hex[i]);
        check("model_ready", int'(req_ready), (m_mode != 1) ? 1 : 0);
        check("model_timeout_cnt", int'(timeout_cnt), m_to);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called just after a negedge; the request is held across exactly one rising edge.
  task automatic do_req(input bit w, input logic [7:0] a, input logic [7:0] d, input bit quiet = 0);
    if (!quiet) $display("txn %s addr=%02h data=%02h t=%0t", w ? "write" : "read", a, d, $time);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic do_rsp(input logic [7:0] d);
    $display("txn response data=%02h t=%0t", d, $time);
    rsp_valid = 1'b1; rsp_rdata = d;
    @(negedge clk);
    rsp_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(2);
    #1;
    check_disp("reset", 20, 20, 20, 20, 20, 20);
    check("reset_ready", int'(req_ready), 1);
    check("reset_to", int'(timeout_cnt), 0);
    rst_n = 1'b1;
    idle(2);

    // Write, then hold expiry
    do_req(1'b1, 8'h3C, 8'hA5);
    check_disp("wr", 18, 31, 3, 12, 10, 5);
    idle(HOLD - 1);
    check_disp("wr_hold", 18, 31, 3, 12, 10, 5);
    idle(1);
    check_disp("wr_idle", 20, 20, 20, 20, 20, 20);

    // Read answered after 3 cycles
    do_req(1'b0, 8'h7F, 8'h00);
    check_disp("rd", 16, 17, 7, 15, 19, 19);
    check("rd_ready", int'(req_ready), 0);
    idle(2);
    do_rsp(8'hE1);
    check_disp("rd_rsp", 16, 17, 7, 15, 14, 1);
    check("rd_rsp_ready", int'(req_ready), 1);
    idle(HOLD);

    // Unanswered read times out on the TO-th edge
    do_req(1'b0, 8'h12, 8'h00);
    idle(TO - 1);
    check("to_pending_hex0", int'(hex0_code), 19);
    idle(1);
    check_disp("to", 16, 17, 1, 2, 21, 21);
    check("to_cnt1", int'(timeout_cnt), 1);
    idle(HOLD);

    // Response on the timeout terminal edge wins
    do_req(1'b0, 8'h40, 8'h00);
    idle(TO - 1);
    do_rsp(8'h9B);
    check_disp("race", 16, 17, 4, 0, 9, 11);
    check("race_cnt", int'(timeout_cnt), 1);
    idle(HOLD);

    // Stray response while idle
    do_rsp(8'h55);
    check_disp("stray", 20, 20, 20, 20, 20, 20);
    idle(2);

    // Write on the hold terminal edge preempts the return to idle
    do_req(1'b1, 8'h01, 8'h02);
    idle(HOLD - 1);
    do_req(1'b1, 8'hFE, 8'hDC);
    check_disp("pre", 18, 31, 15, 14, 13, 12);
    idle(HOLD - 1);
    check_disp("pre_hold", 18, 31, 15, 14, 13, 12);
    idle(1);
    check_disp("pre_idle", 20, 20, 20, 20, 20, 20);

    // 300 back-to-back timeouts saturate the counter
    for (int k = 0; k < 300; k++) begin
      do_req(1'b0, 8'(k), 8'h00, 1'b1);
      idle(TO);
    end
    $display("txn 300 unanswered reads issued t=%0t", $time);
    check("sat_cnt", int'(timeout_cnt), 255);
    check_disp("sat", 16, 17, 2, 11, 21, 21);

    // Reset in the middle of a pending read
    do_req(1'b0, 8'h66, 8'h00);
    idle(1);
    rst_n = 1'b0;
    #1;
    check_disp("midrst", 20, 20, 20, 20, 20, 20);
    check("midrst_ready", int'(req_ready), 1);
    check("midrst_to", int'(timeout_cnt), 0);
    idle(3);
    rst_n = 1'b1;
    idle(TO + 2);
    check("post_rst_to", int'(timeout_cnt), 0);
    check_disp("post_rst", 20, 20, 20, 20, 20, 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_disp_ctrl.md
# mem_disp_ctrl

Sequencer that sits directly upstream of the seven-segment glyph decoders. It snoops memory-controller transactions through a valid/ready request port and a response port, then holds a six-digit status view as 5-bit glyph codes: 0–15 hex, 16 r, 17 d, 18 t, 19 _, 20 -, 21 n, 31 blank. Each `hexN_code` drives one downstream decoder instance at top level. The block also times out unanswered reads and counts them.

## Interface
- `TIMEOUT_CYC`, default 255: cycles a read may wait for its response; ≥2.
- `HOLD_CYC`, default 50_000_000: cycles a completed transaction stays displayed; ≥2.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: transaction request.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in 8: transaction address.
- `req_wdata` in 8: write data.
- `req_ready` out 1: request accept.
- `rsp_valid` in 1: read response strobe.
- `rsp_rdata` in 8: read data.
- `hex5_code` … `hex0_code` out 5 each: glyph codes; hex5 is leftmost.
- `timeout_cnt` out 8: saturating count of read timeouts.

## Operation
- States: IDLE, RD_WAIT, SHOW.
- `req_ready` = 1 in IDLE or SHOW, 0 in RD_WAIT. It is combinational from state.
- A request is accepted on an edge where `req_valid && req_ready`. Address and data are captured on that edge.
- IDLE display: all six digits = 20 (`------`).
- Accepted write, from IDLE or SHOW:
  - Display `t`, blank, addr[7:4], addr[3:0], wdata[7:4], wdata[3:0].
  - Next state SHOW; hold counter cleared.
- Accepted read:
  - Display `r`, `d`, addr[7:4], addr[3:0], 19, 19.
  - Next state RD_WAIT; wait counter cleared.
- RD_WAIT with `rsp_valid`:
  - hex1/hex0 ← rdata[7:4]/rdata[3:0]; other digits unchanged.
  - Next state SHOW; hold counter cleared.
- RD_WAIT timeout, when the wait counter = TIMEOUT_CYC-1 and `rsp_valid`=0:
  - hex1 = hex0 = 21 (`nn`).
  - `timeout_cnt` increments, saturating at 255.
  - Next state SHOW.
- SHOW:
  - Hold counter increments each cycle.
  - At HOLD_CYC-1 with no accepted request, go to IDLE, display `------`.
  - An accepted request preempts the hold immediately, with the same actions as from IDLE.
- `rsp_valid` outside RD_WAIT is ignored.
- Nibble digits are the raw 4-bit value zero-extended to 5 bits.

## Timing
- Reset values:
  - State IDLE; all `hexN_code` = 5'd20.
  - `timeout_cnt` = 0; both counters = 0.
  - `req_ready` = 1.
- All display outputs are registered. New codes are visible in the cycle after the accepting or response edge.
- Timeout fires on the TIMEOUT_CYC-th edge after acceptance (the accept edge is excluded).
- Hold ends on the HOLD_CYC-th edge after entering SHOW.
- A response on the same edge as the timeout terminal count wins: data is shown and there is no timeout count.
- A request in SHOW on the hold terminal edge wins over the return to IDLE.
- Reset asserted mid-operation returns everything to reset values asynchronously. A pending read is abandoned and not counted.
- Counter widths are sized by `$clog2` of the respective parameter.

## Structure
- Package `mem_disp_pkg`:
  - Glyph localparams: GLYPH_R=16, GLYPH_D=17, GLYPH_T=18, GLYPH_US=19, GLYPH_DASH=20, GLYPH_N=21, GLYPH_BLANK=31.
  - State enum.
- Single module, no sub-module. The six glyph decoders are instantiated beside this block at top level, not inside it.

## Test plan
- Reset: assert `rst_n`=0 mid-RD_WAIT → all codes 20, `req_ready`=1, `timeout_cnt`=0.
- Write addr 0x3C, data 0xA5 → codes {18,31,3,12,10,5}. After HOLD_CYC (set 8) cycles → all 20.
- Read addr 0x7F → {16,17,7,15,19,19}, `req_ready`=0. `rsp_rdata`=0xE1 after 3 cycles → hex1/hex0 = 14/1.
- Read with no response, TIMEOUT_CYC=4 → hex1/hex0 = 21 on the 4th edge. `timeout_cnt`=1. Run 300 timeouts → saturates at 255.
- Response on the timeout terminal edge → data shown, `timeout_cnt` unchanged. Stray `rsp_valid` in IDLE → no change.
- Write in SHOW on the hold terminal edge → new write display, stays SHOW, hold restarts.
